// File: rtl/cray_ibuf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cray_ibuf: instruction parcel buffer between the 64-bit memory read port |
// | and the decoder. Optional macro CRAY_IBUF_DEEP_EN: 16-parcel queue.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cray_ibuf #(
  parameter int                ADDR_W   = 22,
  parameter logic [ADDR_W+1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_fetch_req,
  output logic [ADDR_W-1:0] o_fetch_addr,
  input  logic              i_fetch_gnt,
  input  logic [63:0]       i_mem_rd_data,
  output logic              o_instr_valid,
  output logic [31:0]       o_instr,
  output logic              o_instr_long,
  output logic [ADDR_W+1:0] o_instr_pa,
  input  logic              i_instr_ready,
  input  logic              i_branch,
  input  logic [ADDR_W+1:0] i_branch_target
);

`ifdef CRAY_IBUF_DEEP_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 8;
`endif
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FETCH_FREE = CNT_W'(4);

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

  fetch_state_e      state_q, state_d;
  logic [15:0]       mem_q [DEPTH];
  logic [15:0]       mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W+1:0] pa_q, pa_d;
  logic [1:0]        skip_q, skip_d;

  logic [15:0]       w_p0, w_p1;
  logic [PTR_W-1:0]  w_rd_nxt;
  logic              w_long, w_valid, w_pop, w_gnt;
  logic [CNT_W-1:0]  w_pop_n, w_wr_n, w_free;

  // Takes opcode bits [6:1]; bit 0 never affects the length.
  function automatic logic is_long(input logic [5:0] op_hi);
    return (op_hi == 6'b000011) || (op_hi[5:2] == 4'b0001) ||
           (op_hi == 6'b001000) || (op_hi == 6'b010000) ||
           (op_hi[5:4] == 2'b10);
  endfunction

  assign w_rd_nxt = rd_ptr_q + PTR_W'(1);
  assign w_p0     = mem_q[rd_ptr_q];
  assign w_p1     = mem_q[w_rd_nxt];
  assign w_long   = is_long(w_p0[15:10]);
  assign w_valid  = w_long ? (count_q >= CNT_W'(2)) : (count_q != '0);
  assign w_pop    = w_valid & i_instr_ready & ~i_branch;
  assign w_gnt    = i_fetch_gnt & (state_q == ST_REQ) & ~i_branch;
  assign w_pop_n  = w_pop ? (w_long ? CNT_W'(2) : CNT_W'(1)) : '0;
  assign w_wr_n   = w_gnt ? CNT_W'(3'd4 - {1'b0, skip_q}) : '0;

  always_comb begin
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fetch_addr_d = fetch_addr_q;
    pa_d         = pa_q;
    skip_d       = skip_q;
    state_d      = state_q;
    w_free       = '0;
    if (i_branch) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      fetch_addr_d = i_branch_target[ADDR_W+1:2];
      pa_d         = i_branch_target;
      skip_d       = i_branch_target[1:0];
      state_d      = ST_REQ;
    end else begin
      // Leading parcels below the skip count are dropped, the rest pack densely.
      for (int j = 0; j < 4; j++) begin
        if (w_gnt && (2'(j) >= skip_q)) begin
          mem_d[wr_ptr_q + PTR_W'(j) - PTR_W'(skip_q)] = i_mem_rd_data[16*j +: 16];
        end
      end
      rd_ptr_d = rd_ptr_q + PTR_W'(w_pop_n);
      wr_ptr_d = wr_ptr_q + PTR_W'(w_wr_n);
      count_d  = count_q - w_pop_n + w_wr_n;
      pa_d     = pa_q + (ADDR_W+2)'(w_pop_n);
      if (w_gnt) begin
        fetch_addr_d = fetch_addr_q + ADDR_W'(1);
        skip_d       = 2'b00;
      end
      w_free  = DEPTH_C - count_d;
      state_d = (w_free >= FETCH_FREE) ? ST_REQ : ST_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_WAIT;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      fetch_addr_q <= RESET_PC[ADDR_W+1:2];
      pa_q         <= RESET_PC;
      skip_q       <= RESET_PC[1:0];
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fetch_addr_q <= fetch_addr_d;
      pa_q         <= pa_d;
      skip_q       <= skip_d;
    end
  end

  assign o_fetch_req   = (state_q == ST_REQ);
  assign o_fetch_addr  = fetch_addr_q;
  assign o_instr_valid = w_valid;
  assign o_instr       = w_valid ? {w_p0, (w_long ? w_p1 : 16'h0000)} : 32'h0;
  assign o_instr_long  = w_valid & w_long;
  assign o_instr_pa    = pa_q;

endmodule
`default_nettype wire

// File: doc/cray_ibuf.md
# cray_ibuf

Instruction parcel buffer between the 64-bit memory read port and the instruction decoder inside the CPU top level. It prefetches memory words four parcels at a time, queues them, and presents one complete instruction per handshake to the decoder. Both one-parcel and two-parcel forms are presented, including two-parcel instructions that straddle a word boundary. A branch from the decoder flushes the queue and restarts fetch at any parcel address.

## Interface

Parameters:
- `ADDR_W`, default 22: memory word address width.
- `RESET_PC`, default 0: parcel address (`ADDR_W+2` bits) at which fetch starts after reset.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `o_fetch_req`, out, 1: word fetch request.
- `o_fetch_addr`, out, `ADDR_W`: word address of the request.
- `i_fetch_gnt`, in, 1: grant; `i_mem_rd_data` is valid and captured at this edge.
- `i_mem_rd_data`, in, 64: parcel 0 in [15:0], parcel 3 in [63:48].
- `o_instr_valid`, out, 1: a complete instruction is at the head.
- `o_instr`, out, 32: [31:16] first parcel; [15:0] second parcel, or 0 for a one-parcel instruction.
- `o_instr_long`, out, 1: head instruction is two parcels.
- `o_instr_pa`, out, `ADDR_W+2`: parcel address of the head instruction's first parcel.
- `i_instr_ready`, in, 1: decoder accepts the head instruction.
- `i_branch`, in, 1: flush and redirect.
- `i_branch_target`, in, `ADDR_W+2`: redirect parcel address; [1:0] selects the parcel within the word.

## Operation

- Queue: circular parcel FIFO with `DEPTH` = 8 parcels (16 with the macro). Each accepted word is written as 4 parcels in order 0..3.
- Fetch FSM:
  - REQ: `o_fetch_req`=1. Moves to WAIT when free slots drop below 4 after the current grant.
  - WAIT: `o_fetch_req`=0. Returns to REQ when free slots are 4 or more.
  - Each grant increments `o_fetch_addr`, wrapping from 2^`ADDR_W`-1 to 0.
- Skip counter (2 bits): after a redirect, the first `i_branch_target[1:0]` parcels of the first fetched word are dropped and not written.
- Length decode on head parcel bits [15:9] (7-bit opcode). The instruction is long for opcodes 0o006, 0o007, 0o010–0o017, 0o020, 0o021, 0o040, 0o041, 0o100–0o137. All other opcodes are short.
- `o_instr_valid`:
  - Short instruction: valid when occupancy ≥ 1.
  - Long instruction: valid when occupancy ≥ 2. A long instruction whose second parcel is in the next word stays invalid until that word arrives.
- Handshake: when `o_instr_valid`=1 and `i_instr_ready`=1, pop 1 or 2 parcels and advance `o_instr_pa` by 1 or 2, wrapping modulo 2^(`ADDR_W`+2).
- Simultaneous pop and grant in one cycle are both honoured. Free-slot accounting uses post-pop occupancy.
- Branch takes priority over everything in that cycle:
  - FIFO is emptied.
  - A grant in that cycle is discarded.
  - `i_instr_ready` is ignored.
  - `o_fetch_addr` ← target[`ADDR_W`+1:2], `o_instr_pa` ← target, skip ← target[1:0], FSM → REQ.
- Outputs are driven from registered state only. There are no combinational paths from `i_instr_ready` or `i_fetch_gnt`.

## Timing

- Reset values: `o_fetch_req`=0, `o_fetch_addr`=`RESET_PC`[`ADDR_W`+1:2], `o_instr_valid`=0, `o_instr`=0, `o_instr_long`=0, `o_instr_pa`=`RESET_PC`, FIFO empty, skip=`RESET_PC`[1:0].
- `o_fetch_req` rises on the first rising edge after `rst` deasserts.
- Grant at edge N: the instruction is valid in the cycle after edge N.
- Branch at edge N: `o_instr_valid`=0 during cycle N+1. The first post-branch instruction is valid no earlier than the cycle after the first post-branch grant.
- Reset asserted mid-fetch: all state returns to reset values immediately. The in-flight word is lost.
- Full FIFO: `o_fetch_req`=0. A grant arriving while `o_fetch_req`=0 is ignored.

## Configuration

- `CRAY_IBUF_DEEP_EN`:
  - Defined: `DEPTH`=16 parcels (4 words).
  - Undefined: `DEPTH`=8 parcels (2 words).
  - The fetch threshold stays at 4 free slots either way. All other behaviour is identical.

## Test plan

- Reset, then word 0 = {0o022106, 0o155123, 0o077230, 0o072300} granted at the first request: four short instructions issue with `o_instr_pa` = 0, 1, 2, 3, and `o_instr` = {0o072300, 0} first.
- Word 2 = {0, 0o110000, 0, 0o100000}: two long instructions issue, {0o100000, 0} at pa 8 and {0o110000, 0} at pa 10.
- Long 0o006000 placed at parcel 3 of word 4, with its second parcel 0o000012 in word 5: `o_instr_valid` stays 0 until word 5 is granted, then `o_instr` = {0o006000, 0o000012} at pa 19.
- `i_instr_ready` held 0: `o_fetch_req` drops after 2 grants (4 grants with `CRAY_IBUF_DEEP_EN`). After one short pop it stays 0; after 4 pops it rises again.
- `i_branch` with target 0o000006 in the same cycle as a grant: the granted word is discarded, the next `o_fetch_addr` = 1, parcels 4–5 are skipped, and the first issued `o_instr_pa` = 6.
- `rst` pulsed low while `o_instr_valid`=1 and a grant is pending: all outputs return to reset values within the reset cycle, and fetch restarts at `RESET_PC`.
